// File: rtl/matrix_3x3_8bit.sv
// Sliding 3x3 pixel window built from the two-tap line shift RAM.
// Stage 1 aligns the live pixel and sidebands with the RAM taps; stage 2 holds
// the window, the delayed sidebands and the window-valid / line-length flags.
module matrix_3x3_8bit #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CNT_W    = 11,
   parameter int unsigned LINE_MAX = 1024
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              pre_frame_vsync,
   input  logic              pre_frame_href,
   input  logic              pre_frame_clken,
   input  logic [DATA_W-1:0] pre_img_y,
   output logic              shift_href,
   output logic              shift_clken,
   output logic [DATA_W-1:0] shift_data,
   input  logic [DATA_W-1:0] taps0x,
   input  logic [DATA_W-1:0] taps1x,
   output logic              matrix_frame_vsync,
   output logic              matrix_frame_href,
   output logic              matrix_frame_clken,
   output logic [DATA_W-1:0] matrix_p11,
   output logic [DATA_W-1:0] matrix_p12,
   output logic [DATA_W-1:0] matrix_p13,
   output logic [DATA_W-1:0] matrix_p21,
   output logic [DATA_W-1:0] matrix_p22,
   output logic [DATA_W-1:0] matrix_p23,
   output logic [DATA_W-1:0] matrix_p31,
   output logic [DATA_W-1:0] matrix_p32,
   output logic [DATA_W-1:0] matrix_p33,
   output logic              matrix_valid,
   output logic              err_line_len
);

   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] ERR_COL = CNT_W'(LINE_MAX + 1);
   localparam logic [CNT_W-1:0] ROW_MIN = CNT_W'(2);
   localparam logic [CNT_W-1:0] COL_MIN = CNT_W'(3);

   logic              vsync_d1;
   logic              href_d1;
   logic              clken_d1;
   logic [DATA_W-1:0] y_d1;

   logic [CNT_W-1:0]  col_cnt;
   logic [CNT_W-1:0]  row_cnt;
   logic [CNT_W-1:0]  col_next;
   logic [CNT_W-1:0]  row_next;
   logic              href_fall;
   logic              vsync_rise;
   logic              err_set;
   logic              err_next;
   logic              valid_next;

   // Line RAM is fed straight from the input port
   assign shift_href  = pre_frame_href;
   assign shift_clken = pre_frame_clken;
   assign shift_data  = pre_img_y;

   // Stage 1: align the live pixel and sidebands with the one-cycle RAM taps
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d1 <= 1'b0;
         href_d1  <= 1'b0;
         clken_d1 <= 1'b0;
         y_d1     <= '0;
      end else begin
         vsync_d1 <= pre_frame_vsync;
         href_d1  <= pre_frame_href;
         clken_d1 <= pre_frame_clken;
         y_d1     <= pre_img_y;
      end
   end

   // Edge detects use the stage-2 sideband copies as the previous stage-1 value
   assign href_fall  = matrix_frame_href & ~href_d1;
   assign vsync_rise = vsync_d1 & ~matrix_frame_vsync;

   // Next counter and flag values; the window flag uses the updated column
   always_comb begin
      col_next   = col_cnt;
      row_next   = row_cnt;
      err_set    = 1'b0;
      err_next   = err_line_len;
      valid_next = 1'b0;

      if (!href_d1) begin
         col_next = '0;
      end else if (clken_d1 && (col_cnt != CNT_SAT)) begin
         col_next = col_cnt + CNT_ONE;
      end

      if (vsync_rise) begin
         row_next = '0;
      end else if (href_fall && (row_cnt != CNT_SAT)) begin
         row_next = row_cnt + CNT_ONE;
      end

      err_set = href_d1 & clken_d1 & (col_next == ERR_COL);

      if (vsync_rise) begin
         err_next = 1'b0;
      end else if (err_set) begin
         err_next = 1'b1;
      end

      valid_next = clken_d1 & href_d1 &
                   (row_cnt >= ROW_MIN) & (col_next >= COL_MIN) &
                   ~(err_line_len | err_set);
   end

   // Row/column position and the sticky over-length flag
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt      <= '0;
         row_cnt      <= '0;
         err_line_len <= 1'b0;
         matrix_valid <= 1'b0;
      end else begin
         col_cnt      <= col_next;
         row_cnt      <= row_next;
         err_line_len <= err_next;
         matrix_valid <= valid_next;
      end
   end

   // Window: shift on a strobe, clear between lines, otherwise hold
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         matrix_p11 <= '0;
         matrix_p12 <= '0;
         matrix_p13 <= '0;
         matrix_p21 <= '0;
         matrix_p22 <= '0;
         matrix_p23 <= '0;
         matrix_p31 <= '0;
         matrix_p32 <= '0;
         matrix_p33 <= '0;
      end else if (clken_d1) begin
         matrix_p11 <= matrix_p12;
         matrix_p12 <= matrix_p13;
         matrix_p13 <= taps1x;
         matrix_p21 <= matrix_p22;
         matrix_p22 <= matrix_p23;
         matrix_p23 <= taps0x;
         matrix_p31 <= matrix_p32;
         matrix_p32 <= matrix_p33;
         matrix_p33 <= y_d1;
      end else if (!href_d1) begin
         matrix_p11 <= '0;
         matrix_p12 <= '0;
         matrix_p13 <= '0;
         matrix_p21 <= '0;
         matrix_p22 <= '0;
         matrix_p23 <= '0;
         matrix_p31 <= '0;
         matrix_p32 <= '0;
         matrix_p33 <= '0;
      end
   end

   // Stage 2 sidebands, aligned with the window registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         matrix_frame_vsync <= 1'b0;
         matrix_frame_href  <= 1'b0;
         matrix_frame_clken <= 1'b0;
      end else begin
         matrix_frame_vsync <= vsync_d1;
         matrix_frame_href  <= href_d1;
         matrix_frame_clken <= clken_d1;
      end
   end

endmodule

// File: doc/matrix_3x3_8bit.md
Name: matrix_3x3_8bit

Overview:
- Drives the two-tap 8-bit line shift RAM and consumes its taps to form a sliding 3x3 pixel window for 3x3 filters (Sobel, median, erosion/dilation) in the camera-to-LCD grayscale path.
- Sits between the grayscale conversion stage and the filter stage.
- Outputs the 9 window pixels and delayed frame sync, line valid and clock enable, plus a flag marking fully-populated windows.

Parameters:
- DATA_W, 8, pixel width; fixed by the line RAM.
- CNT_W, 11, width of the row and column counters.
- LINE_MAX, 1024, line RAM depth; the longest legal line in pixels.

Ports:
- clock  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pre_frame_vsync  in  1  input frame sync, active high.
- pre_frame_href  in  1  input line valid.
- pre_frame_clken  in  1  input pixel strobe.
- pre_img_y  in  8  input grayscale pixel.
- shift_href  out  1  to line RAM pre_frame_href; combinational copy of pre_frame_href.
- shift_clken  out  1  to line RAM clken; combinational copy of pre_frame_clken.
- shift_data  out  8  to line RAM shiftin; combinational copy of pre_img_y.
- taps0x  in  8  from line RAM; previous line, same column.
- taps1x  in  8  from line RAM; line before previous, same column.
- matrix_frame_vsync  out  1  pre_frame_vsync delayed 2 cycles.
- matrix_frame_href  out  1  pre_frame_href delayed 2 cycles.
- matrix_frame_clken  out  1  pre_frame_clken delayed 2 cycles.
- matrix_p11..p13  out  8 each  top row (oldest line), left to right.
- matrix_p21..p23  out  8 each  middle row.
- matrix_p31..p33  out  8 each  bottom row (current line); p33 is the newest pixel.
- matrix_valid  out  1  window fully inside the image (rows >= 3, columns >= 3).
- err_line_len  out  1  sticky: some line exceeded LINE_MAX pixels in this frame.

Behaviour:
- Reset (async, rst_n=0): every register and every registered output is 0. Shift outputs still follow inputs combinationally.
- Tap timing: taps0x/taps1x for a pixel accepted at cycle n (pre_frame_clken=1) are valid at cycle n+1. pre_img_y, clken, href and vsync are registered once (the _d1 stage) to align with the taps.
- Window shift, at a clock edge with clken_d1=1:
  - each row shifts left: pX1 <= pX2, pX2 <= pX3.
  - p13 <= taps1x, p23 <= taps0x, p33 <= y_d1.
- Window hold: with clken_d1=0, the window holds.
- Window clear: with href_d1=0, all nine window registers clear to 0, so each line starts clean.
- Latency: pixel accepted at cycle n appears as p33 at cycle n+2, together with matrix_frame_clken=1. Sidebands are registered twice, so all outputs are aligned.
- Column counter:
  - increments on clken_d1 while href_d1=1; cleared while href_d1=0.
  - saturates at 2^CNT_W-1.
  - counts the pixel being shifted in (first pixel = 1).
- Row counter:
  - increments on each falling edge of href_d1, saturating.
  - cleared on a rising edge of vsync_d1.
  - counts completed lines.
- matrix_valid:
  - registered; asserted for the window produced by a shift where row_cnt >= 2 and the new col value >= 3.
  - otherwise 0, including every cycle where matrix_frame_clken=0.
- err_line_len:
  - set when col_cnt reaches LINE_MAX+1 within one line (line RAM address wrap corrupts taps).
  - cleared on vsync_d1 rising edge.
  - while set, matrix_valid is forced 0.
- Simultaneous events:
  - vsync rising in the same cycle as an href falling edge: the row clear wins and row_cnt becomes 0.
  - href falling in the same cycle as clken_d1=1: this pixel still shifts, and the clear applies from the next cycle.
- Mid-frame reset: outputs return to 0 immediately. After release, row_cnt=0, so no valid window until two full lines plus three pixels have passed.
- Clken gaps within a line (clken low with href high): the window and counters freeze; no output strobe.

Test Plan:
- Reset then idle, all inputs 0 -> all outputs 0; shift_* equal inputs in the same cycle.
- Frame of 3 lines x 4 pixels, pixel = 16*line+col, taps modelled by a 1-cycle-latency behavioural line RAM -> first matrix_valid at line 2 col 3, two cycles after that pixel's clken. Window there: p11..p13=00,01,02; p21..p23=10,11,12; p31..p33=20,21,22. The next window is valid and shifted one column.
- Clken toggling 1,0,1,0 within a line -> matrix_frame_clken mirrors the pattern 2 cycles later; the window holds during gaps; col_cnt does not advance.
- Line of 1025 pixels with LINE_MAX=1024 -> err_line_len=1 from pixel 1025 onward; matrix_valid stays 0 until the next vsync rising edge, then err_line_len clears.
- Assert rst_n=0 mid-line for 1 cycle -> all outputs 0 next edge. Then resume mid-frame -> no matrix_valid until 2 further href falling edges plus 3 pixels.
- New vsync after 5 lines -> row_cnt clears, and the first two lines of the new frame give matrix_valid=0.
